// File: rtl/branch_resolve.sv
// Memory-boundary branch/trap resolution: drives fetch redirects, owns machine trap CSRs
// and minstret, and squashes wrong-path instructions after each redirect.
module branch_resolve #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__pc,
  input  logic        ex_mb__branch,
  input  logic        ex_mb__cond,
  input  logic [31:0] ex_mb__target,
  input  logic        ex_mb__predict_taken,
  input  logic        ex_mb__ins_misalign,
  input  logic        ex_mb__illegal,
  input  logic        ex_mb__ecall,
  input  logic        ex_mb__mret,
  input  logic        ex_mb__csr_we,
  input  logic [11:0] ex_mb__csr_addr,
  input  logic [31:0] ex_mb__csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [31:0] mb_if__jump_target,
  output logic        mb_if__branch_taken,
  output logic        mb_if__trap_taken,
  output logic        mb_if__predict_taken,
  output logic [31:0] mb_if__pc_4
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_KILL = 1'b1;

  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

  logic [XLEN-1:0] jump_target_q, jump_target_d;
  logic            branch_taken_q, branch_taken_d;
  logic            trap_taken_q, trap_taken_d;
  logic            predict_taken_q, predict_taken_d;
  logic [XLEN-1:0] pc_4_q, pc_4_d;

  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:2] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     minstret_q, minstret_d;

  logic            live_c;
  logic            trap_c;
  logic [XLEN-1:0] cause_c;
  logic [XLEN-1:0] tval_c;
  logic            redirect_c;

  assign live_c = ex_mb__valid && (state_q == ST_RUN);

  // Trap detection, first match wins
  always_comb begin
    trap_c  = 1'b0;
    cause_c = '0;
    tval_c  = '0;
    if (ex_mb__ins_misalign) begin
      trap_c  = 1'b1;
      cause_c = 32'd0;
      tval_c  = ex_mb__pc;
    end else if (ex_mb__illegal) begin
      trap_c  = 1'b1;
      cause_c = 32'd2;
    end else if (ex_mb__ecall) begin
      trap_c  = 1'b1;
      cause_c = 32'd11;
    end else if (ex_mb__branch && ex_mb__cond && (ex_mb__target[1:0] != 2'b00)) begin
      trap_c  = 1'b1;
      cause_c = 32'd0;
      tval_c  = ex_mb__target;
    end
  end

  always_comb begin
    state_d         = state_q;
    kill_cnt_d      = kill_cnt_q;
    jump_target_d   = '0;
    branch_taken_d  = 1'b0;
    trap_taken_d    = 1'b0;
    predict_taken_d = 1'b0;
    pc_4_d          = '0;
    mtvec_d         = mtvec_q;
    mepc_d          = mepc_q;
    mcause_d        = mcause_q;
    mtval_d         = mtval_q;
    minstret_d      = minstret_q;
    redirect_c      = 1'b0;

    if (state_q == ST_KILL) begin
      if (kill_cnt_q <= CNT_W'(1)) begin
        state_d    = ST_RUN;
        kill_cnt_d = '0;
      end else begin
        kill_cnt_d = kill_cnt_q - CNT_W'(1);
      end
    end

    if (live_c) begin
      pc_4_d = ex_mb__pc + 32'd4;
      if (trap_c) begin
        trap_taken_d  = 1'b1;
        jump_target_d = {mtvec_q[XLEN-1:2], 2'b00};
        mepc_d        = ex_mb__pc[XLEN-1:2];
        mcause_d      = cause_c;
        mtval_d       = tval_c;
        redirect_c    = 1'b1;
      end else begin
        minstret_d = minstret_q + 64'd1;
        if (ex_mb__mret) begin
          branch_taken_d = 1'b1;
          jump_target_d  = {mepc_q, 2'b00};
          redirect_c     = 1'b1;
        end else begin
          jump_target_d = ex_mb__target;
          if (ex_mb__branch) begin
            branch_taken_d  = ex_mb__cond;
            predict_taken_d = ex_mb__predict_taken;
            redirect_c      = (ex_mb__cond != ex_mb__predict_taken);
          end
        end
        // CSR write overrides the retire increment for the half it targets
        if (ex_mb__csr_we) begin
          case (ex_mb__csr_addr)
            A_MTVEC:     mtvec_d  = ex_mb__csr_wdata;
            A_MEPC:      mepc_d   = ex_mb__csr_wdata[XLEN-1:2];
            A_MCAUSE:    mcause_d = ex_mb__csr_wdata;
            A_MTVAL:     mtval_d  = ex_mb__csr_wdata;
            A_MINSTRET:  minstret_d[31:0]  = ex_mb__csr_wdata;
            A_MINSTRETH: minstret_d[63:32] = ex_mb__csr_wdata;
            default: ;
          endcase
        end
      end
      if (redirect_c) begin
        state_d    = ST_KILL;
        kill_cnt_d = CNT_W'(KILL_CYCLES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      kill_cnt_q      <= '0;
      jump_target_q   <= '0;
      branch_taken_q  <= 1'b0;
      trap_taken_q    <= 1'b0;
      predict_taken_q <= 1'b0;
      pc_4_q          <= '0;
      mtvec_q         <= MTVEC_RESET;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      minstret_q      <= '0;
    end else begin
      state_q         <= state_d;
      kill_cnt_q      <= kill_cnt_d;
      jump_target_q   <= jump_target_d;
      branch_taken_q  <= branch_taken_d;
      trap_taken_q    <= trap_taken_d;
      predict_taken_q <= predict_taken_d;
      pc_4_q          <= pc_4_d;
      mtvec_q         <= mtvec_d;
      mepc_q          <= mepc_d;
      mcause_q        <= mcause_d;
      mtval_q         <= mtval_d;
      minstret_q      <= minstret_d;
    end
  end

  // Combinational CSR read port
  always_comb begin
    case (ex_mb__csr_addr)
      A_MTVEC:     csr_rdata = mtvec_q;
      A_MEPC:      csr_rdata = {mepc_q, 2'b00};
      A_MCAUSE:    csr_rdata = mcause_q;
      A_MTVAL:     csr_rdata = mtval_q;
      A_MINSTRET:  csr_rdata = minstret_q[31:0];
      A_MINSTRETH: csr_rdata = minstret_q[63:32];
      default:     csr_rdata = '0;
    endcase
  end

  assign mb_if__jump_target   = jump_target_q;
  assign mb_if__branch_taken  = branch_taken_q;
  assign mb_if__trap_taken    = trap_taken_q;
  assign mb_if__predict_taken = predict_taken_q;
  assign mb_if__pc_4          = pc_4_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of redirects, traps, CSRs and the squash window.
module tb_branch_resolve;

  localparam int unsigned KILL = 2;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid, branch, cond, pred, misal, illegal, ecall, mret, csr_we;
  logic [31:0] pc, target, wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, jt;
  logic        bt, trap, pt;
  logic [31:0] pc4;

  branch_resolve #(.KILL_CYCLES(KILL), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mb__valid(valid), .ex_mb__pc(pc), .ex_mb__branch(branch), .ex_mb__cond(cond),
    .ex_mb__target(target), .ex_mb__predict_taken(pred), .ex_mb__ins_misalign(misal),
    .ex_mb__illegal(illegal), .ex_mb__ecall(ecall), .ex_mb__mret(mret),
    .ex_mb__csr_we(csr_we), .ex_mb__csr_addr(csr_addr), .ex_mb__csr_wdata(wdata),
    .csr_rdata(csr_rdata), .mb_if__jump_target(jt), .mb_if__branch_taken(bt),
    .mb_if__trap_taken(trap), .mb_if__predict_taken(pt), .mb_if__pc_4(pc4)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model architectural state
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_instret;
  int          m_kill;
  // Model expectations for the next registered outputs
  logic [31:0] e_jt, e_pc4;
  logic        e_bt, e_trap, e_pt, e_chk_jt, e_chk_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc & 32'hFFFF_FFFC;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_instret = 0; m_kill = 0;
    e_jt = 0; e_pc4 = 0; e_bt = 0; e_trap = 0; e_pt = 0; e_chk_jt = 1; e_chk_pc4 = 1;
  endtask

  // One instruction slot: what fetch must see next and how architectural state moves
  task automatic model_step();
    logic [63:0] n;
    bit is_trap;
    int cause;
    logic [31:0] tval;
    e_jt = 0; e_pc4 = 0; e_bt = 0; e_trap = 0; e_pt = 0; e_chk_jt = 1; e_chk_pc4 = 1;
    if (!(valid && m_kill == 0)) begin
      if (m_kill > 0) m_kill--;
      return;
    end
    is_trap = 1; cause = 0; tval = 0;
    if (misal) begin cause = 0; tval = pc; end
    else if (illegal) cause = 2;
    else if (ecall) cause = 11;
    else if (branch && cond && target[1:0] != 2'b00) begin cause = 0; tval = target; end
    else is_trap = 0;
    e_pc4 = pc + 32'd4;
    if (is_trap) begin
      e_trap = 1; e_jt = m_mtvec & 32'hFFFF_FFFC; e_chk_pc4 = 0;
      m_mepc = pc; m_mcause = cause; m_mtval = tval;
      m_kill = KILL;
      return;
    end
    if (mret) begin
      e_bt = 1; e_jt = m_mepc & 32'hFFFF_FFFC; e_chk_pc4 = 0;
      m_kill = KILL;
    end else if (branch) begin
      e_bt = cond; e_pt = pred; e_jt = target;
      if (cond != pred) m_kill = KILL;
    end else begin
      e_chk_jt = 0;
    end
    n = m_instret + 64'd1;
    if (csr_we) begin
      case (csr_addr)
        12'h305: m_mtvec = wdata;
        12'h341: m_mepc = wdata;
        12'h342: m_mcause = wdata;
        12'h343: m_mtval = wdata;
        12'hB02: n[31:0] = wdata;
        12'hB82: n[63:32] = wdata;
        default: ;
      endcase
    end
    m_instret = n;
  endtask

  task automatic idle();
    valid = 0; pc = 0; branch = 0; cond = 0; target = 0; pred = 0; misal = 0;
    illegal = 0; ecall = 0; mret = 0; csr_we = 0; csr_addr = 0; wdata = 0;
  endtask

  // Called at a falling edge with inputs already driven
  task automatic tick();
    #1;
    chk("csr_rdata", csr_rdata, m_read(csr_addr));
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("trap_taken", 32'(trap), 32'(e_trap));
    chk("branch_taken", 32'(bt), 32'(e_bt));
    chk("predict_taken", 32'(pt), 32'(e_pt));
    if (e_chk_jt) chk("jump_target", jt, e_jt);
    if (e_chk_pc4) chk("pc_4", pc4, e_pc4);
  endtask

  task automatic read_lit(input logic [11:0] a, input logic [31:0] exp, input string name);
    idle();
    csr_addr = a;
    #1 chk(name, csr_rdata, exp);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    model_reset();
    #1;
    chk("rst_jt", jt, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_flags", {29'h0, bt, trap, pt}, 32'h0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic instr(input logic [31:0] p);
    idle(); valid = 1; pc = p;
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    do_reset();
    read_lit(12'h305, MTVEC_RST, "rst_mtvec");

    // Plain instruction
    instr(32'h40); tick();
    chk("lit_pc4_0x44", pc4, 32'h44);
    chk("lit_plain_bt", 32'(bt), 32'h0);
    read_lit(12'hB02, 32'd1, "lit_minstret_1");

    // Mispredicted taken branch, then two squashed instructions
    instr(32'h100); branch = 1; cond = 1; pred = 0; target = 32'h200; tick();
    chk("lit_br_bt", 32'(bt), 32'h1);
    chk("lit_br_jt", jt, 32'h200);
    instr(32'h104); tick();
    chk("lit_kill1_pc4", pc4, 32'h0);
    instr(32'h108); tick();
    chk("lit_kill2_pc4", pc4, 32'h0);
    read_lit(12'hB02, 32'd2, "lit_minstret_2");

    // mtvec write, ecall, mret
    instr(32'h44); csr_we = 1; csr_addr = 12'h305; wdata = 32'h80; tick();
    instr(32'h50); ecall = 1; tick();
    chk("lit_ecall_trap", 32'(trap), 32'h1);
    chk("lit_ecall_jt", jt, 32'h80);
    read_lit(12'h341, 32'h50, "lit_mepc");
    read_lit(12'h342, 32'd11, "lit_mcause_11");
    read_lit(12'hB02, 32'd3, "lit_minstret_3");
    instr(32'h54); mret = 1; tick();
    chk("lit_mret_bt", 32'(bt), 32'h1);
    chk("lit_mret_jt", jt, 32'h50);
    chk("lit_mret_pt", 32'(pt), 32'h0);
    idle(); tick(); tick();

    // Misaligned taken target, then same with illegal also set
    instr(32'h300); branch = 1; cond = 1; pred = 1; target = 32'h202; tick();
    chk("lit_misal_trap", 32'(trap), 32'h1);
    read_lit(12'h342, 32'd0, "lit_mcause_0");
    read_lit(12'h343, 32'h202, "lit_mtval");
    read_lit(12'h341, 32'h300, "lit_mepc_br");
    instr(32'h310); branch = 1; cond = 1; pred = 1; target = 32'h202; illegal = 1; tick();
    read_lit(12'h342, 32'd2, "lit_mcause_2");
    read_lit(12'h343, 32'h0, "lit_mtval_0");

    // minstret carry and pc_4 wrap
    instr(32'h60); csr_we = 1; csr_addr = 12'hB02; wdata = 32'hFFFF_FFFF; tick();
    instr(32'h64); tick();
    read_lit(12'hB02, 32'h0, "lit_minstret_lo");
    read_lit(12'hB82, 32'h1, "lit_minstreth");
    instr(32'hFFFF_FFFC); branch = 1; cond = 0; pred = 0; target = 32'h8; tick();
    chk("lit_pc4_wrap", pc4, 32'h0);

    // Reset while squashing
    instr(32'h70); branch = 1; cond = 1; pred = 0; target = 32'h400; tick();
    do_reset();
    instr(32'h60); tick();
    chk("lit_post_rst_pc4", pc4, 32'h64);
    read_lit(12'hB02, 32'd1, "lit_post_rst_minstret");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      valid   = ($urandom_range(9) < 8);
      pc      = ($urandom_range(19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      branch  = ($urandom_range(9) < 4);
      cond    = 1'($urandom_range(1));
      pred    = 1'($urandom_range(1));
      target  = $urandom();
      if ($urandom_range(9) != 0) target[1:0] = 2'b00;
      misal   = ($urandom_range(19) == 0);
      illegal = ($urandom_range(19) == 0);
      ecall   = ($urandom_range(19) == 0);
      mret    = ($urandom_range(19) == 0);
      csr_we  = ($urandom_range(6) == 0);
      case ($urandom_range(6))
        0: csr_addr = 12'h305;
        1: csr_addr = 12'h341;
        2: csr_addr = 12'h342;
        3: csr_addr = 12'h343;
        4: csr_addr = 12'hB02;
        5: csr_addr = 12'hB82;
        default: csr_addr = 12'($urandom_range(4095));
      endcase
      wdata = $urandom();
      if (csr_addr == 12'h341) wdata[1:0] = 2'b00;
      if (csr_addr == 12'hB02 && $urandom_range(3) == 0) wdata = 32'hFFFF_FFFE;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Memory-boundary stage; drives the mb_if__ redirect bus that the fetch stage consumes.
- Resolves branches and jumps from execute against the fetch-time prediction.
- Raises traps, executes mret, owns the machine trap CSRs and the retired-instruction counter.
- Sits between execute (ex_mb__ inputs) and fetch (mb_if__ outputs). Suppresses wrong-path instructions after every redirect it issues.

Parameters:
- KILL_CYCLES, 2: cycles of ex_mb__ input ignored after a redirect (wrong-path depth between fetch and this stage). Legal range 1..7.
- MTVEC_RESET, 32'h00000000: reset value of mtvec.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- ex_mb__valid in 1: instruction present (not a bubble).
- ex_mb__pc in 32: instruction PC.
- ex_mb__branch in 1: instruction is a branch or jump.
- ex_mb__cond in 1: branch condition true; 1 for jumps.
- ex_mb__target in 32: computed branch/jump target.
- ex_mb__predict_taken in 1: prediction carried from fetch.
- ex_mb__ins_misalign in 1: fetch-address misalign flag.
- ex_mb__illegal in 1: illegal instruction.
- ex_mb__ecall in 1: ecall.
- ex_mb__mret in 1: mret.
- ex_mb__csr_we in 1: CSR write request.
- ex_mb__csr_addr in 12: CSR address.
- ex_mb__csr_wdata in 32: CSR write data.
- csr_rdata out 32: combinational read of ex_mb__csr_addr; 0 for unmapped addresses.
- mb_if__jump_target out 32: redirect target.
- mb_if__branch_taken out 1: resolved taken.
- mb_if__trap_taken out 1: trap redirect.
- mb_if__predict_taken out 1: echoed prediction.
- mb_if__pc_4 out 32: fall-through PC.

Behaviour:
- Reset (async, rst_n=0):
  - all mb_if__ outputs 0; mepc, mcause, mtval, minstret 0; mtvec=MTVEC_RESET; state RUN.
  - Reset mid-kill returns to RUN immediately.
- "live" = ex_mb__valid && state==RUN.
- When not live, the next-cycle mb_if__ outputs are all 0. Fetch mispredict detection (branch_taken != predict_taken) must see equal zeros on idle cycles.
- Latency: all mb_if__ outputs are registered, 1 cycle after the ex_mb__ inputs.
- Trap priority, first match wins (evaluated only when live):
  1. ins_misalign: cause 0, mtval=pc.
  2. illegal: cause 2, mtval=0.
  3. ecall: cause 11, mtval=0.
  4. taken branch (branch && cond) with target[1:0]!=0: cause 0, mtval=target.
- Trap effects:
  - mepc<=pc, mcause<=cause, mtval as above.
  - Outputs: trap_taken=1, jump_target={mtvec[31:2],2'b00}, branch_taken=0, predict_taken=0.
  - The instruction does not retire, and its CSR write is discarded.
- mret (live, no trap): branch_taken=1, jump_target=mepc, predict_taken=0. This is a forced mispredict.
- Branch (live, no trap, not mret):
  - branch_taken=cond; predict_taken=ex_mb__predict_taken; jump_target=target.
  - pc_4=pc+4 modulo 2^32 (0xFFFFFFFC wraps to 0).
  - Non-branch live instructions: branch_taken=0, predict_taken=0.
- Redirect issued = trap, mret, or (branch && cond != predict_taken).
  - On a redirect: state RUN -> KILL, counter loaded with KILL_CYCLES.
  - KILL decrements each cycle; on reaching 0 it returns to RUN, so exactly KILL_CYCLES input cycles are ignored.
  - In KILL: no retire, no CSR write, no redirect.
- CSR map: mtvec 0x305 (RW), mepc 0x341 (RW, bits[1:0] read 0), mcause 0x342 (RW), mtval 0x343 (RW), minstret 0xB02 (RW low), minstreth 0xB82 (RW high).
- CSR write applies at the clock edge when live && csr_we && no trap.
- minstret (64 bits) increments by 1 per live non-trapping instruction and wraps at 2^64.
  - A CSR write to minstret/minstreth in the same cycle wins over the increment for that half.
- Correctly predicted branches issue no redirect and cause no KILL.

Test Plan:
- Reset, then valid non-branch pc=0x40 -> next cycle all mb_if__ 0 except pc_4=0x44; minstret=1.
- Branch pc=0x100, cond=1, predict=0, target=0x200 -> branch_taken=1, predict_taken=0, jump_target=0x200. The next 2 valid inputs are ignored: no outputs, minstret unchanged.
- Write mtvec=0x80, then ecall at pc=0x50 -> trap_taken=1, jump_target=0x80, mepc=0x50, mcause=11, minstret not incremented. Follow with mret -> branch_taken=1, jump_target=0x50.
- Taken branch with target=0x202 -> trap cause 0, mtval=0x202, mepc=branch pc. Same cycle with illegal=1 -> cause 2 wins.
- minstret=0xFFFFFFFF plus one retire -> minstret low 0, minstreth 1. pc=0xFFFFFFFC branch not taken -> pc_4=0.
- Assert rst_n low during KILL -> outputs 0, state RUN; the next valid instruction is processed normally.
